// File: rtl/draw_number_field.sv
`default_nettype none
// ============================================================================
// Module  : draw_number_field
// Purpose : Overlays a DIGITS-wide decimal number, drawn with 16x16 font
//           glyphs, onto the VGA stream.
// Rev     : 1.0  initial release
// ============================================================================
module draw_number_field #(
    parameter int          VALUE_W         = 14,
    parameter int          DIGITS          = 4,
    parameter int          RECT_X          = 504,
    parameter int          RECT_Y          = 376,
    parameter int          GLYPH_BASE      = 1,
    parameter logic [11:0] FONT_COLOR      = 12'hFFF,
    parameter int          LEAD_ZERO_BLANK = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               show,
    input  logic [VALUE_W-1:0] value,
    input  logic [10:0]        bus_in_hcount,
    input  logic               bus_in_hsync,
    input  logic               bus_in_hblnk,
    input  logic [10:0]        bus_in_vcount,
    input  logic               bus_in_vsync,
    input  logic               bus_in_vblnk,
    input  logic [11:0]        bus_in_rgb,
    output logic [10:0]        bus_out_hcount,
    output logic               bus_out_hsync,
    output logic               bus_out_hblnk,
    output logic [10:0]        bus_out_vcount,
    output logic               bus_out_vsync,
    output logic               bus_out_vblnk,
    output logic [11:0]        bus_out_rgb,
    input  logic [15:0]        char_pixels,
    output logic [10:0]        address,
    output logic               busy
);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint             c_MAX_L    = pow10(DIGITS) - 1;
    localparam logic [VALUE_W-1:0] c_MAX      = VALUE_W'(c_MAX_L);
    localparam bit                 c_SAT_EN   = ((longint'(1) << VALUE_W) - 1) > c_MAX_L;
    localparam int                 c_BCD_W    = 4 * DIGITS;
    localparam int                 c_CNT_W    = $clog2(VALUE_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(VALUE_W - 1);
    localparam logic [10:0]        c_X0       = 11'(RECT_X);
    localparam logic [10:0]        c_X1       = 11'(RECT_X + 16 * DIGITS);
    localparam logic [10:0]        c_Y0       = 11'(RECT_Y);
    localparam logic [10:0]        c_Y1       = 11'(RECT_Y + 16);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        w_busy;
    logic                        r_vblnk_prev;
    logic                        w_sample;
    logic [VALUE_W-1:0]          w_sat_value;
    logic [VALUE_W-1:0]          r_sv;
    logic [c_BCD_W-1:0]          r_bcd;
    logic [c_BCD_W-1:0]          w_bcd_adj;
    logic [c_BCD_W+VALUE_W-1:0]  w_shift;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [c_BCD_W-1:0]          r_digits;

    assign w_sample    = bus_in_vblnk & ~r_vblnk_prev;
    assign w_sat_value = (c_SAT_EN && (value > c_MAX)) ? c_MAX : value;

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    assign w_shift = {w_bcd_adj, r_sv} << 1;

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sample) w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (r_cnt == c_CNT_LAST) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_busy       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vblnk_prev <= 1'b0;
            r_sv         <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_digits     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_vblnk_prev <= bus_in_vblnk;
            case (r_state)
                S_IDLE: begin
                    if (w_sample) begin
                        r_sv  <= w_sat_value;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    {r_bcd, r_sv} <= w_shift;
                    r_cnt         <= r_cnt + 1'b1;
                end
                S_LOAD: r_digits <= r_bcd;
                default: begin
                end
            endcase
        end
    end

    assign busy = w_busy;

    logic        w_in_field;
    logic [10:0] w_dx;
    logic [3:0]  w_row;
    logic [6:0]  w_pos;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic        w_zero_run;
    logic [6:0]  w_glyph;
    logic [10:0] w_addr;

    assign w_in_field = (bus_in_hcount >= c_X0) && (bus_in_hcount < c_X1) &&
                        (bus_in_vcount >= c_Y0) && (bus_in_vcount < c_Y1);
    assign w_dx  = bus_in_hcount - c_X0;
    assign w_row = 4'(bus_in_vcount - c_Y0);
    assign w_pos = w_dx[10:4];

    // Position 0 is the most significant digit; a position is blank while
    // every digit from the MSD down to it is zero, except the last one.
    always_comb begin
        w_digit    = '0;
        w_blank    = 1'b0;
        w_zero_run = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_zero_run = w_zero_run & (r_digits[c_BCD_W-4-4*i +: 4] == 4'd0);
            if (w_pos == 7'(i)) begin
                w_digit = r_digits[c_BCD_W-4-4*i +: 4];
                w_blank = (LEAD_ZERO_BLANK != 0) && (i < DIGITS - 1) && w_zero_run;
            end
        end
    end

    assign w_glyph = 7'(GLYPH_BASE) + {3'b000, w_digit};
    assign w_addr  = w_in_field ? {w_glyph, w_row} : 11'd0;

    logic [10:0] r1_hcount, r1_vcount;
    logic        r1_hsync, r1_hblnk, r1_vsync, r1_vblnk;
    logic [11:0] r1_rgb;
    logic        r1_in_field, r1_blank, r1_show;
    logic [3:0]  r1_col;
    logic [10:0] r_address;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_hcount   <= '0;
            r1_hsync    <= 1'b0;
            r1_hblnk    <= 1'b0;
            r1_vcount   <= '0;
            r1_vsync    <= 1'b0;
            r1_vblnk    <= 1'b0;
            r1_rgb      <= '0;
            r1_in_field <= 1'b0;
            r1_blank    <= 1'b0;
            r1_show     <= 1'b0;
            r1_col      <= '0;
            r_address   <= '0;
        end else begin
            r1_hcount   <= bus_in_hcount;
            r1_hsync    <= bus_in_hsync;
            r1_hblnk    <= bus_in_hblnk;
            r1_vcount   <= bus_in_vcount;
            r1_vsync    <= bus_in_vsync;
            r1_vblnk    <= bus_in_vblnk;
            r1_rgb      <= bus_in_rgb;
            r1_in_field <= w_in_field;
            r1_blank    <= w_blank;
            r1_show     <= show;
            r1_col      <= w_dx[3:0];
            r_address   <= w_addr;
        end
    end

    assign address = r_address;

    // The ROM answers the registered address within this stage.
    logic [3:0] w_bit_idx;
    logic       w_px;
    logic       w_draw;

    assign w_bit_idx = 4'd15 - r1_col;
    assign w_px      = r1_in_field ? char_pixels[w_bit_idx] : 1'b0;
    assign w_draw    = r1_show & r1_in_field & ~r1_blank & w_px;

    logic [10:0] r2_hcount, r2_vcount;
    logic        r2_hsync, r2_hblnk, r2_vsync, r2_vblnk;
    logic [11:0] r2_rgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_hcount <= '0;
            r2_hsync  <= 1'b0;
            r2_hblnk  <= 1'b0;
            r2_vcount <= '0;
            r2_vsync  <= 1'b0;
            r2_vblnk  <= 1'b0;
            r2_rgb    <= '0;
        end else begin
            r2_hcount <= r1_hcount;
            r2_hsync  <= r1_hsync;
            r2_hblnk  <= r1_hblnk;
            r2_vcount <= r1_vcount;
            r2_vsync  <= r1_vsync;
            r2_vblnk  <= r1_vblnk;
            r2_rgb    <= w_draw ? FONT_COLOR : r1_rgb;
        end
    end

    assign bus_out_hcount = r2_hcount;
    assign bus_out_hsync  = r2_hsync;
    assign bus_out_hblnk  = r2_hblnk;
    assign bus_out_vcount = r2_vcount;
    assign bus_out_vsync  = r2_vsync;
    assign bus_out_vblnk  = r2_vblnk;
    assign bus_out_rgb    = r2_rgb;

endmodule
`default_nettype wire

// File: tb/tb_draw_number_field.sv
`default_nettype none
// ============================================================================
// Module  : tb_draw_number_field
// Purpose : Self-checking bench for draw_number_field.
// Rev     : 1.0  initial release
// ============================================================================
module tb_draw_number_field;

    localparam int          VALUE_W    = 14;
    localparam int          DIGITS     = 4;
    localparam int          RECT_X     = 504;
    localparam int          RECT_Y     = 376;
    localparam int          GLYPH_BASE = 1;
    localparam logic [11:0] FONT       = 12'hFFF;
    localparam int          LZB        = 1;
    localparam int          MAXV       = 9999;

    logic               clk = 1'b0;
    logic               rst;
    logic               show;
    logic [VALUE_W-1:0] value;
    logic [10:0]        bi_hcount, bi_vcount;
    logic               bi_hsync, bi_hblnk, bi_vsync, bi_vblnk;
    logic [11:0]        bi_rgb;
    logic [10:0]        bo_hcount, bo_vcount;
    logic               bo_hsync, bo_hblnk, bo_vsync, bo_vblnk;
    logic [11:0]        bo_rgb;
    logic [15:0]        char_pixels;
    logic [10:0]        address;
    logic               busy;

    always #5 clk = ~clk;

    draw_number_field dut (
        .clk(clk), .rst(rst), .show(show), .value(value),
        .bus_in_hcount(bi_hcount), .bus_in_hsync(bi_hsync), .bus_in_hblnk(bi_hblnk),
        .bus_in_vcount(bi_vcount), .bus_in_vsync(bi_vsync), .bus_in_vblnk(bi_vblnk),
        .bus_in_rgb(bi_rgb),
        .bus_out_hcount(bo_hcount), .bus_out_hsync(bo_hsync), .bus_out_hblnk(bo_hblnk),
        .bus_out_vcount(bo_vcount), .bus_out_vsync(bo_vsync), .bus_out_vblnk(bo_vblnk),
        .bus_out_rgb(bo_rgb),
        .char_pixels(char_pixels), .address(address), .busy(busy)
    );

    // Pseudo font: every address returns a distinct, irregular pixel row.
    function automatic logic [15:0] rom(input logic [10:0] a);
        logic [31:0] h;
        h = {21'd0, a} * 32'h9E3779B1;
        return h[23:8] ^ {5'd0, a};
    endfunction

    assign char_pixels = rom(address);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [10:0] hc;
        logic        hs;
        logic        hb;
        logic [10:0] vc;
        logic        vs;
        logic        vb;
        logic [11:0] rgb;
        logic        show;
        logic        vis;
        int          col;
        logic [10:0] addr;
    } stage_t;

    stage_t e1, e2;
    int     m_disp, m_pend, m_cnt;
    bit     m_prev;

    function automatic logic [37:0] pack(input stage_t s);
        return {s.hc, s.hs, s.hb, s.vc, s.vs, s.vb, s.rgb};
    endfunction

    always @(posedge clk) begin : model
        int h, v, p, d, pw;
        logic [15:0] rw;
        if (rst) begin
            m_cnt = 0; m_disp = 0; m_pend = 0; m_prev = 1'b0;
            e1 = '{default: 0};
            e2 = '{default: 0};
        end else begin
            e2 = e1;
            rw = rom(e1.addr);
            e2.rgb = (e1.show && e1.vis && rw[15 - e1.col]) ? FONT : e1.rgb;
            h = int'(bi_hcount);
            v = int'(bi_vcount);
            e1.hc = bi_hcount; e1.hs = bi_hsync; e1.hb = bi_hblnk;
            e1.vc = bi_vcount; e1.vs = bi_vsync; e1.vb = bi_vblnk;
            e1.rgb = bi_rgb; e1.show = show;
            if (h >= RECT_X && h < RECT_X + 16 * DIGITS && v >= RECT_Y && v < RECT_Y + 16) begin
                p  = (h - RECT_X) / 16;
                pw = pow10(DIGITS - 1 - p);
                d  = (m_disp / pw) % 10;
                e1.addr = 11'((GLYPH_BASE + d) * 16 + (v - RECT_Y));
                e1.col  = (h - RECT_X) % 16;
                e1.vis  = !(LZB != 0 && p < DIGITS - 1 && m_disp < pw);
            end else begin
                e1.addr = 11'd0;
                e1.col  = 0;
                e1.vis  = 1'b0;
            end
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_disp = m_pend;
            end else if (bi_vblnk && !m_prev) begin
                m_pend = (int'(value) > MAXV) ? MAXV : int'(value);
                m_cnt  = VALUE_W + 1;
            end
            m_prev = bi_vblnk;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bus_out", {26'd0, bo_hcount, bo_hsync, bo_hblnk, bo_vcount, bo_vsync, bo_vblnk, bo_rgb},
                {26'd0, pack(e2)});
            chk("address", {53'd0, address}, {53'd0, e1.addr});
            chk("busy", {63'd0, busy}, {63'd0, (m_cnt > 0)});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic set_px(input int h, input int v);
        bi_hcount = 11'(h);
        bi_vcount = 11'(v);
    endtask

    task automatic frame_sample(input int val);
        value    = VALUE_W'(val);
        bi_vblnk = 1'b1;
        @(negedge clk);
        bi_vblnk = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic addr_at(input string name, input int h, input int v, input int exp);
        set_px(h, v);
        @(posedge clk);
        #1;
        chk(name, {53'd0, address}, 64'(exp));
        @(negedge clk);
    endtask

    typedef struct {
        int val;
        int h;
        int v;
        int exp_addr;
    } vec_t;

    vec_t        tbl[12];
    int          n;
    logic [15:0] rp;

    initial begin
        tbl[0]  = '{1234,  523, 381,  53};
        tbl[1]  = '{7,     504, 376,  16};
        tbl[2]  = '{7,     554, 391, 143};
        tbl[3]  = '{0,     554, 380,  20};
        tbl[4]  = '{16383, 520, 386, 170};
        tbl[5]  = '{16383, 567, 376, 160};
        tbl[6]  = '{9999,  503, 380,   0};
        tbl[7]  = '{5000,  568, 380,   0};
        tbl[8]  = '{5000,  504, 392,   0};
        tbl[9]  = '{5000,  504, 375,   0};
        tbl[10] = '{10000, 540, 377, 161};
        tbl[11] = '{42,    540, 377,  81};

        rst = 1'b1; show = 1'b1; value = '0;
        bi_hcount = '0; bi_vcount = '0; bi_hsync = 1'b0; bi_hblnk = 1'b0;
        bi_vsync = 1'b0; bi_vblnk = 1'b0; bi_rgb = '0;
        repeat (2) @(negedge clk);
        chk("reset_bus_out", {26'd0, bo_hcount, bo_hsync, bo_hblnk, bo_vcount, bo_vsync, bo_vblnk, bo_rgb}, 64'd0);
        chk("reset_address", {53'd0, address}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // busy width for one conversion
        value = VALUE_W'(1234);
        bi_vblnk = 1'b1;
        @(negedge clk);
        bi_vblnk = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) n++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'd15);

        // glyph pixel of digit '2', column 3, row 5
        bi_rgb = 12'h0A5;
        set_px(523, 381);
        @(posedge clk); #1;
        chk("digit_addr", {53'd0, address}, 64'd53);
        @(posedge clk); #1;
        rp = rom(11'd53);
        chk("digit_rgb", {52'd0, bo_rgb}, {52'd0, (rp[12] ? 12'hFFF : 12'h0A5)});
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            frame_sample(tbl[i].val);
            addr_at("tbl_addr", tbl[i].h, tbl[i].v, tbl[i].exp_addr);
        end

        // value change without a sample event must not alter the display
        frame_sample(1234);
        value = VALUE_W'(42);
        repeat (5) @(negedge clk);
        addr_at("midframe_old", 523, 381, 53);
        frame_sample(42);
        addr_at("midframe_new_p2", 536, 376, 80);
        addr_at("midframe_new_p3", 552, 376, 48);

        // passthrough when show is low
        show = 1'b0;
        bi_rgb = 12'h3C7;
        set_px(540, 380);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("show0_rgb", {52'd0, bo_rgb}, 64'h3C7);
        chk("show0_hcount", {53'd0, bo_hcount}, 64'd540);
        @(negedge clk);
        show = 1'b1;

        // reset five cycles into the conversion
        value = VALUE_W'(5678);
        bi_vblnk = 1'b1;
        @(negedge clk);
        bi_vblnk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_bus_out", {26'd0, bo_hcount, bo_hsync, bo_hblnk, bo_vcount, bo_vsync, bo_vblnk, bo_rgb}, 64'd0);
        chk("rst_mid_address", {53'd0, address}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        addr_at("rst_mid_zero", 556, 378, 18);

        // randomized traffic around the field against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bi_hcount = 11'(RECT_X - 8 + int'($urandom_range(0, 80)));
            bi_vcount = 11'(RECT_Y - 4 + int'($urandom_range(0, 24)));
            bi_hsync  = 1'($urandom);
            bi_hblnk  = 1'($urandom);
            bi_vsync  = 1'($urandom);
            bi_rgb    = 12'($urandom);
            show      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) bi_vblnk = ~bi_vblnk;
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 1) == 1) value = VALUE_W'($urandom);
                else value = VALUE_W'($urandom_range(0, 120));
            end
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/draw_number_field.md
Name: draw_number_field

Overview:
- Renders a multi-digit unsigned decimal number (score, timer, lives) as 16x16 font glyphs into a rectangle of the VGA stream.
- Sits in the vga_bus pipeline between background/object drawers and the output stage, and shares the font ROM through char_pixels/address.
- Converts the binary value to BCD sequentially, once per frame at vblank start, so the display is stable across a frame.
- Supports a configurable digit count, optional leading-zero blanking and saturation.

Parameters:
- VALUE_W, 14: width of the binary input value.
- DIGITS, 4: number of decimal digit positions; MAX = 10^DIGITS-1.
- RECT_X, 504: hcount of the left edge of the most significant digit.
- RECT_Y, 376: vcount of the top edge of the field.
- GLYPH_BASE, 1: font ROM glyph index of character '0'; digit d uses glyph GLYPH_BASE+d.
- FONT_COLOR, 12'hFFF: rgb of set glyph pixels.
- LEAD_ZERO_BLANK, 1: 1 blanks leading zeros; 0 shows all digits.

Ports:
- clk  input  1  pixel clock.
- rst  input  1  synchronous active-high reset.
- show  input  1  1 = draw the field; 0 = rgb passthrough.
- value  input  VALUE_W  binary number to display; sampled once per frame.
- bus_in  vga_bus  -  incoming timing and rgb.
- bus_out  vga_bus  -  outgoing timing and rgb.
- char_pixels  input  16  font row from the ROM, 1-cycle read latency; bit 15 is the leftmost column.
- address  output  11  font ROM address (registered).
- busy  output  1  conversion in progress.

Behaviour:
- Reset (clk edge with rst=1):
  - all bus_out fields = 0; address = 0; busy = 0.
  - FSM goes to IDLE; displayed digit register = all 0.
  - A reset in mid-conversion abandons it; the field then shows "0" (LEAD_ZERO_BLANK=1) or all zeros (LEAD_ZERO_BLANK=0).
- Frame sample:
  - Sample event = bus_in.vblnk rising edge (registered previous vblnk=0, current=1).
  - On the sample event in IDLE: latch sv = (value > MAX) ? MAX : value. Saturation uses a VALUE_W-wide compare; MAX is a constant.
- Converter FSM, IDLE -> SHIFT -> LOAD -> IDLE:
  - SHIFT runs exactly VALUE_W cycles of double-dabble: for each 4-bit BCD digit, add 3 if >=5, then shift {bcd,sv} left by 1.
  - LOAD (1 cycle) copies the BCD result into the displayed digit register.
  - busy = 1 in SHIFT and LOAD.
  - The display updates at the clock edge ending LOAD, VALUE_W+1 cycles after the sample edge.
  - A sample event while busy is ignored.
  - value changes outside the sample event have no effect until the next frame.
- Geometry:
  - Field spans hcount in [RECT_X, RECT_X+16*DIGITS) and vcount in [RECT_Y, RECT_Y+16).
  - Position p = (hcount-RECT_X)>>4, with p=0 the most significant digit; col = (hcount-RECT_X)&15; row = vcount-RECT_Y.
- Pipeline, 2-cycle latency:
  - Stage 1: register bus_in fields, in-field flag, col, blank flag and show.
  - Stage 1 also registers address = (GLYPH_BASE+digit[p])*16+row when in field, else 0.
  - Stage 2: bus_out timing fields = stage-1 copies. bus_out.rgb = FONT_COLOR if show & in_field & !blank & char_pixels[15-col], else the stage-1 rgb.
- Blanking: with LEAD_ZERO_BLANK=1, position p is blank if digits 0..p are all zero and p < DIGITS-1. The least significant digit is never blank.
- Widths: all geometry comparisons use 11-bit unsigned arithmetic. Pixels outside the field never index char_pixels.

Test Plan:
- DIGITS=4, value=1234, one vblnk rise: busy=1 for exactly 15 cycles (14 SHIFT + 1 LOAD). At hcount=RECT_X+16+3, vcount=RECT_Y+5, address = (1+2)*16+5 = 53. Two cycles later bus_out.rgb = FFF iff char_pixels[12].
- value=7, LEAD_ZERO_BLANK=1: positions 0-2 output bus_in.rgb delayed by 2 cycles; position 3 draws glyph 8. value=0 shows a single "0" in position 3.
- value=16383 (>9999): displayed digits = 9,9,9,9, i.e. addresses 160+row for all positions.
- value changed from 1234 to 42 mid-frame: the current frame still shows 1234; after the next vblnk rise plus 15 cycles it shows "42".
- show=0 with the field in view: bus_out equals bus_in delayed by 2 cycles on all fields.
- rst asserted 5 cycles into SHIFT: next cycle busy=0, bus_out all 0, address=0; the next frame shows "0" until a new sample completes.
